mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
- Iterative multi-cycle multiply unit and its sequencing FSM for the multi-cycle ARM core.
- Replaces the single-cycle combinational multipliers in the ALU datapath for MUL, UMULL and SMULL.
- Uses a radix-2 shift-add engine with a start/busy/done handshake. The main control FSM stalls on busy and writes back result_lo/result_hi and flags when done pulses.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. Only 32 is verified.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- op  input  2  operation: 00 MUL (low 32 bits), 01 UMULL, 10 SMULL, 11 reserved.
- a  input  WIDTH  multiplicand (Rn/Rm operand from the register file path).
- b  input  WIDTH  multiplier.
- busy  output  1  high while the unit is not in IDLE.
- done  output  1  single-cycle pulse; results are valid in this cycle.
- result_lo  output  WIDTH  product bits [31:0].
- result_hi  output  WIDTH  product bits [63:32]; 0 for MUL and reserved ops.
- flags  output  4  {N,Z,C,V}, same order as the ALU flags bus.

Behaviour:
Reset:
- Synchronous reset forces IDLE and clears busy, done, result_lo, result_hi, flags and all internal registers.
- Reset mid-operation aborts the operation: no done pulse and no partial result visible.
- Reset has priority over start.

States and transitions:
- IDLE: if start=1, latch a, b and op, then go to PREP. Otherwise stay in IDLE.
- PREP (1 cycle):
  - SMULL: record sign = a[31]^b[31]; replace the operands with their two's-complement magnitudes.
  - MUL, UMULL, reserved: sign = 0; operands unchanged.
  - Clear the 64-bit accumulator and the 5-bit counter; go to RUN.
- RUN (exactly 32 cycles, no early exit):
  - If the multiplier LSB is 1, add the multiplicand into the accumulator upper half, with carry out kept.
  - Shift {carry, accumulator, multiplier} right by 1.
  - Increment the counter. When the counter wraps from 31 to 0, go to FIX.
- FIX (1 cycle):
  - If sign=1, negate the 64-bit product.
  - Register result_lo/result_hi and flags; go to DONE.
- DONE (1 cycle): done=1; go to IDLE.

Latency:
- The start-accept edge is edge 0. PREP runs after edge 0, RUN after edges 1..32, FIX after edge 33, DONE after edge 34.
- done is therefore high in the 35th cycle after acceptance. Latency is fixed and independent of data.
- busy = (state != IDLE), including the DONE cycle. start in the DONE cycle is ignored; the earliest re-accept is the cycle after done.

Operand and result handling:
- start while busy is ignored (not queued).
- Input a, b and op changes after acceptance have no effect.
- result_lo, result_hi and flags hold their values from done until the next FIX; they are not cleared on the next start.

Arithmetic rules:
- Magnitude of 0x80000000 is 0x80000000, treated as unsigned, so the SMULL extremes are exact.
- MUL result is the low 32 bits of the unsigned product, identical to the signed low word; result_hi = 0.
- Reserved op: same latency; result_lo = result_hi = 0.

Flags:
- MUL and reserved: N = result_lo[31]; Z = (result_lo == 0).
- UMULL and SMULL: N = result_hi[31]; Z = ({result_hi, result_lo} == 0).
- C = 0 and V = 0 for every op.

Test Plan:
- MUL a=7, b=6: start pulse -> busy high the next cycle; done exactly 35 cycles after acceptance; result_lo=0x0000002A, result_hi=0, flags=0000.
- UMULL a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, flags N=1 Z=0 C=0 V=0.
- SMULL:
  - a=0xFFFFFFFD (-3), b=5 -> {hi,lo}=0xFFFFFFFF_FFFFFFF1, N=1.
  - a=b=0x80000000 -> 0x40000000_00000000, N=0.
  - a=0, b=0x12345678 -> all zeros, Z=1.
- Handshake: hold start=1 continuously with changing operands -> one operation per 36 cycles; each result uses the operands latched at its accept edge; start during DONE is not accepted.
- Reset asserted 10 cycles into a UMULL -> next cycle busy=0, outputs zero, no done pulse; a new MUL 3*3 then completes normally with 9.
- Reserved op=11, a=5, b=5 -> done at cycle 35, results 0, flags Z=1, N=C=V=0.

Source files
------------

// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mul_sequencer
//  Description : Iterative radix-2 shift-add multiply unit (MUL / UMULL /
//                SMULL) with a start/busy/done handshake. A fixed 35-cycle
//                latency from the accept edge to the done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [3:0]       flags
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_PREP = 3'd1;
    localparam logic [2:0] c_S_RUN  = 3'd2;
    localparam logic [2:0] c_S_FIX  = 3'd3;
    localparam logic [2:0] c_S_DONE = 3'd4;

    localparam logic [1:0] c_OP_MUL   = 2'b00;
    localparam logic [1:0] c_OP_UMULL = 2'b01;
    localparam logic [1:0] c_OP_SMULL = 2'b10;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2:0]         r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_hi;
    logic [3:0]         r_flags;

    logic [WIDTH-1:0]   w_mag_mcand;
    logic [WIDTH-1:0]   w_mag_mplier;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_res_lo;
    logic [WIDTH-1:0]   w_res_hi;
    logic               w_n;
    logic               w_z;

    // Two's-complement magnitudes; 0x80000000 maps to itself and is then
    // treated as unsigned, which keeps the SMULL extremes exact.
    assign w_mag_mcand  = r_mcand[WIDTH-1]  ? (~r_mcand + 1'b1)  : r_mcand;
    assign w_mag_mplier = r_mplier[WIDTH-1] ? (~r_mplier + 1'b1) : r_mplier;

    // One shift-add step: the extra MSB of w_sum is the carry that gets
    // shifted back into the accumulator top bit.
    assign w_addend = r_mplier[0] ? r_mcand : '0;
    assign w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    // Restore the sign of an SMULL product from the unsigned magnitude product.
    assign w_prod = r_sign ? (~r_acc + 1'b1) : r_acc;

    // Per-op result selection and N/Z derivation, captured in FIX.
    always_comb begin
        w_res_lo = '0;
        w_res_hi = '0;
        case (r_op)
            c_OP_MUL: begin
                w_res_lo = w_prod[WIDTH-1:0];
            end
            c_OP_UMULL, c_OP_SMULL: begin
                w_res_lo = w_prod[WIDTH-1:0];
                w_res_hi = w_prod[2*WIDTH-1:WIDTH];
            end
            default: begin
                w_res_lo = '0;
                w_res_hi = '0;
            end
        endcase
        if ((r_op == c_OP_UMULL) || (r_op == c_OP_SMULL)) begin
            w_n = w_res_hi[WIDTH-1];
            w_z = ({w_res_hi, w_res_lo} == '0);
        end else begin
            w_n = w_res_lo[WIDTH-1];
            w_z = (w_res_lo == '0);
        end
    end

    // Sequencing FSM plus datapath registers; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_S_IDLE;
            r_op     <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_sign   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_lo     <= '0;
            r_hi     <= '0;
            r_flags  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_op     <= op;
                        r_busy   <= 1'b1;
                        r_state  <= c_S_PREP;
                    end
                end
                c_S_PREP: begin
                    if (r_op == c_OP_SMULL) begin
                        r_sign   <= r_mcand[WIDTH-1] ^ r_mplier[WIDTH-1];
                        r_mcand  <= w_mag_mcand;
                        r_mplier <= w_mag_mplier;
                    end else begin
                        r_sign <= 1'b0;
                    end
                    r_acc   <= '0;
                    r_cnt   <= '0;
                    r_state <= c_S_RUN;
                end
                c_S_RUN: begin
                    r_acc    <= {w_sum, r_acc[WIDTH-1:1]};
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_S_FIX;
                    end
                end
                c_S_FIX: begin
                    r_lo    <= w_res_lo;
                    r_hi    <= w_res_hi;
                    r_flags <= {w_n, w_z, 1'b0, 1'b0};
                    r_done  <= 1'b1;
                    r_state <= c_S_DONE;
                end
                c_S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result_lo = r_lo;
    assign result_hi = r_hi;
    assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_sequencer
//  Description : Self-checking bench for mul_sequencer against a plain
//                arithmetic reference model and directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [3:0]  flags;

    int n_cmp = 0;
    int n_err = 0;

    mul_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: full-precision products via plain 64-bit arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                      output logic [31:0] lo, output logic [31:0] hi, output logic [3:0] fl);
        logic [63:0] p;
        logic [63:0] sx;
        logic [63:0] sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        case (o)
            2'b00:   begin p = {32'd0, x} * {32'd0, y}; lo = p[31:0]; hi = 32'd0; end
            2'b01:   begin p = {32'd0, x} * {32'd0, y}; lo = p[31:0]; hi = p[63:32]; end
            2'b10:   begin p = sx * sy; lo = p[31:0]; hi = p[63:32]; end
            default: begin lo = 32'd0; hi = 32'd0; end
        endcase
        if (o == 2'b01 || o == 2'b10) fl = {hi[31], ({hi, lo} == 64'd0), 2'b00};
        else                          fl = {lo[31], (lo == 32'd0), 2'b00};
    endfunction

    // Issue one operation from IDLE and return the cycle count to done (-1 on timeout).
    task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (result_lo !== 32'd0) begin n_err++; $display("FAIL reset_lo: got %h want 0", result_lo); end
        n_cmp++; if (result_hi !== 32'd0) begin n_err++; $display("FAIL reset_hi: got %h want 0", result_hi); end
        n_cmp++; if (flags !== 4'd0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", flags); end
        reset = 1'b0;
    endtask

    task automatic test_mul();
        int lat;
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 32'd7; b = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = 2'b01;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 1) begin
                n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mul_busy_rise: got %b want 1", busy); end
            end
            if (done === 1'b1) begin lat = k; break; end
        end
        n_cmp++; if (lat != 35) begin n_err++; $display("FAIL mul_latency: got %0d want 35", lat); end
        n_cmp++; if (result_lo !== 32'h2A) begin n_err++; $display("FAIL mul_lo: got %h want 0000002a", result_lo); end
        n_cmp++; if (result_hi !== 32'd0) begin n_err++; $display("FAIL mul_hi: got %h want 0", result_hi); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL mul_flags: got %b want 0000", flags); end
        @(negedge clk);
        n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mul_after_done: got done=%b busy=%b want 0 0", done, busy); end
        repeat (3) @(negedge clk);
        n_cmp++; if (result_lo !== 32'h2A) begin n_err++; $display("FAIL mul_hold: got %h want 0000002a", result_lo); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        int lat;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'hFFFF_FFFF; b = 32'h8765_4321;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", done); end
        n_cmp++; if ({result_hi, result_lo} !== 64'd0) begin n_err++; $display("FAIL abort_result: got %h want 0", {result_hi, result_lo}); end
        n_cmp++; if (flags !== 4'd0) begin n_err++; $display("FAIL abort_flags: got %b want 0000", flags); end
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
        do_op(2'b00, 32'd3, 32'd3, lat);
        n_cmp++; if (lat != 35) begin n_err++; $display("FAIL abort_next_lat: got %0d want 35", lat); end
        n_cmp++; if (result_lo !== 32'd9 || result_hi !== 32'd0) begin n_err++; $display("FAIL abort_next_result: got %h_%h want 0_9", result_hi, result_lo); end
        n_cmp++; if (flags !== 4'b0000) begin n_err++; $display("FAIL abort_next_flags: got %b want 0000", flags); end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op [5];
        logic [31:0] t_a  [5];
        logic [31:0] t_b  [5];
        logic [63:0] t_p  [5];
        logic [3:0]  t_f  [5];
        int lat;
        t_op[0] = 2'b01; t_a[0] = 32'hFFFF_FFFF; t_b[0] = 32'hFFFF_FFFF; t_p[0] = 64'hFFFF_FFFE_0000_0001; t_f[0] = 4'b1000;
        t_op[1] = 2'b10; t_a[1] = 32'hFFFF_FFFD; t_b[1] = 32'd5;         t_p[1] = 64'hFFFF_FFFF_FFFF_FFF1; t_f[1] = 4'b1000;
        t_op[2] = 2'b10; t_a[2] = 32'h8000_0000; t_b[2] = 32'h8000_0000; t_p[2] = 64'h4000_0000_0000_0000; t_f[2] = 4'b0000;
        t_op[3] = 2'b10; t_a[3] = 32'd0;         t_b[3] = 32'h1234_5678; t_p[3] = 64'd0;                   t_f[3] = 4'b0100;
        t_op[4] = 2'b11; t_a[4] = 32'd5;         t_b[4] = 32'd5;         t_p[4] = 64'd0;                   t_f[4] = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], lat);
            n_cmp++; if (lat != 35) begin n_err++; $display("FAIL dir%0d_latency: got %0d want 35", i, lat); end
            n_cmp++; if ({result_hi, result_lo} !== t_p[i]) begin n_err++; $display("FAIL dir%0d_result: got %h_%h want %h", i, result_hi, result_lo, t_p[i]); end
            n_cmp++; if (flags !== t_f[i]) begin n_err++; $display("FAIL dir%0d_flags: got %b want %b", i, flags, t_f[i]); end
        end
    endtask

    task automatic test_random();
        logic [1:0]  o;
        logic [31:0] x, y, elo, ehi;
        logic [3:0]  ef;
        int lat;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom);
            x = $urandom;
            y = $urandom;
            if (i % 6 == 1) x = 32'h8000_0000;
            if (i % 6 == 3) y = 32'hFFFF_FFFF;
            if (i % 6 == 5) x = 32'd0;
            ref_model(o, x, y, elo, ehi, ef);
            do_op(o, x, y, lat);
            n_cmp++; if (lat != 35) begin n_err++; $display("FAIL rnd%0d_latency: got %0d want 35", i, lat); end
            n_cmp++; if (result_lo !== elo || result_hi !== ehi) begin n_err++; $display("FAIL rnd%0d_result op=%b a=%h b=%h: got %h_%h want %h_%h", i, o, x, y, result_hi, result_lo, ehi, elo); end
            n_cmp++; if (flags !== ef) begin n_err++; $display("FAIL rnd%0d_flags: got %b want %b", i, flags, ef); end
        end
    endtask

    // start held high with fresh operands every cycle: accepts land every 36 edges.
    task automatic test_back_to_back();
        logic [31:0] qa [108];
        logic [31:0] qb [108];
        logic [1:0]  qo [108];
        logic [31:0] elo, ehi;
        logic [3:0]  ef;
        logic        exp_done, exp_busy;
        int          acc;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 108; c++) begin
            if (c > 0) @(negedge clk);
            exp_done = (c % 36 == 35);
            exp_busy = (c % 36 != 0);
            n_cmp++; if (done !== exp_done) begin n_err++; $display("FAIL b2b_done c=%0d: got %b want %b", c, done, exp_done); end
            n_cmp++; if (busy !== exp_busy) begin n_err++; $display("FAIL b2b_busy c=%0d: got %b want %b", c, busy, exp_busy); end
            if (exp_done) begin
                acc = c - 35;
                ref_model(qo[acc], qa[acc], qb[acc], elo, ehi, ef);
                n_cmp++; if (result_lo !== elo || result_hi !== ehi || flags !== ef) begin
                    n_err++;
                    $display("FAIL b2b_result c=%0d: got %h_%h/%b want %h_%h/%b", c, result_hi, result_lo, flags, ehi, elo, ef);
                end
            end
            qa[c] = $urandom;
            qb[c] = $urandom;
            qo[c] = 2'($urandom);
            a = qa[c]; b = qb[c]; op = qo[c];
            start = (c != 107);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul();
        test_reset_abort();
        test_directed();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
